// File: rtl/click_detect.sv
// rtl/click_detect.sv - debounced left-button click detector with clamped click position
//
// Purpose: synchronizes the raw left-button level, debounces press and release
// with a shared saturating counter, and emits one strobe per accepted press
// together with the cursor position captured at press start, clamped to the screen.
//
// Ports:
//   clk_75      in   1   single clock, rising edge
//   rst         in   1   synchronous active-high reset
//   mouse_left  in   1   raw left-button level (may be asynchronous)
//   mouse_xpos  in  12   cursor x, clk_75 domain
//   mouse_ypos  in  12   cursor y, clk_75 domain
//   click_e     out  1   one-cycle strobe per accepted click
//   click_x     out 12   clamped x of last accepted click
//   click_y     out 12   clamped y of last accepted click

module click_detect #(
    parameter int DEBOUNCE_CYCLES = 75000,
    parameter int SCREEN_W        = 1024,
    parameter int SCREEN_H        = 768
) (
    input  logic        clk_75,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic        click_e,
    output logic [11:0] click_x,
    output logic [11:0] click_y
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [19:0] LP_CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [12:0] LP_W        = 13'(SCREEN_W);
    localparam logic [12:0] LP_H        = 13'(SCREEN_H);
    localparam logic [11:0] LP_X_MAX    = 12'(SCREEN_W - 1);
    localparam logic [11:0] LP_Y_MAX    = 12'(SCREEN_H - 1);

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic [19:0] r_cnt;
    logic [11:0] r_samp_x;
    logic [11:0] r_samp_y;
    logic        r_click_e;
    logic [11:0] r_click_x;
    logic [11:0] r_click_y;

    logic        w_btn_s;
    logic [19:0] w_cnt_inc;
    logic [11:0] w_clamp_x;
    logic [11:0] w_clamp_y;

    assign w_btn_s = r_sync2;

    // Saturating increment: the counter holds at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == 20'hFFFFF) ? r_cnt : r_cnt + 20'd1;

    // Compare in 13 bits so a screen limit of 4096 never truncates.
    assign w_clamp_x = ({1'b0, r_samp_x} >= LP_W) ? LP_X_MAX : r_samp_x;
    assign w_clamp_y = ({1'b0, r_samp_y} >= LP_H) ? LP_Y_MAX : r_samp_y;

    assign click_e = r_click_e;
    assign click_x = r_click_x;
    assign click_y = r_click_y;

    always_ff @(posedge clk_75) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= 20'd0;
            r_samp_x  <= 12'd0;
            r_samp_y  <= 12'd0;
            r_click_e <= 1'b0;
            r_click_x <= 12'd0;
            r_click_y <= 12'd0;
        end else begin
            r_sync1   <= mouse_left;
            r_sync2   <= r_sync1;
            r_click_e <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_btn_s) begin
                        // Position is taken at press start so motion during
                        // debounce does not move the click.
                        r_state  <= ST_PRESS_WAIT;
                        r_cnt    <= 20'd0;
                        r_samp_x <= mouse_xpos;
                        r_samp_y <= mouse_ypos;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_btn_s) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_state   <= ST_HELD;
                        r_click_e <= 1'b1;
                        r_click_x <= w_clamp_x;
                        r_click_y <= w_clamp_y;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!w_btn_s) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= 20'd0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_btn_s) begin
                        r_state <= ST_HELD;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_click_detect.sv
// tb/tb_click_detect.sv - randomized and directed bench for click_detect against a run-length model

module tb_click_detect;

    localparam int D = 4;
    localparam int W = 1024;
    localparam int H = 768;

    logic        clk_75 = 1'b0;
    logic        rst = 1'b1;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_xpos = 12'd0;
    logic [11:0] mouse_ypos = 12'd0;
    logic        click_e;
    logic [11:0] click_x;
    logic [11:0] click_y;

    int n_cmp = 0;
    int n_bad = 0;

    click_detect #(
        .DEBOUNCE_CYCLES(D),
        .SCREEN_W(W),
        .SCREEN_H(H)
    ) dut (
        .clk_75(clk_75),
        .rst(rst),
        .mouse_left(mouse_left),
        .mouse_xpos(mouse_xpos),
        .mouse_ypos(mouse_ypos),
        .click_e(click_e),
        .click_x(click_x),
        .click_y(click_y)
    );

    always #5 clk_75 = ~clk_75;

    function automatic logic [11:0] clampv(logic [11:0] v, int lim);
        return (int'(v) >= lim) ? 12'(lim - 1) : v;
    endfunction

    // Behavioural model: the button level seen two edges late; a level opposite
    // to the accepted one must persist for D+1 consecutive samples to be accepted.
    int          cyc = 0;
    bit          started = 0;
    bit          m_s1, m_s2, m_s, m_acc;
    int          m_run;
    logic [11:0] m_px, m_py;
    logic        exp_e = 1'b0;
    logic [11:0] exp_x = 12'd0;
    logic [11:0] exp_y = 12'd0;

    always @(posedge clk_75) begin
        cyc++;
        started = 1;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_acc = 0; m_run = 0;
            m_px = 12'd0; m_py = 12'd0;
            exp_e = 1'b0; exp_x = 12'd0; exp_y = 12'd0;
        end else begin
            m_s  = m_s2;
            m_s2 = m_s1;
            m_s1 = mouse_left;
            exp_e = 1'b0;
            if (m_s != m_acc) begin
                m_run++;
                if (m_run == 1 && !m_acc) begin
                    m_px = mouse_xpos;
                    m_py = mouse_ypos;
                end
                if (m_run == D + 1) begin
                    m_acc = m_s;
                    m_run = 0;
                    if (m_s) begin
                        exp_e = 1'b1;
                        exp_x = clampv(m_px, W);
                        exp_y = clampv(m_py, H);
                    end
                end
            end else begin
                m_run = 0;
            end
        end
    end

    // Compare process and click monitor, sampled on the falling edge.
    int n_clicks = 0;
    int last_cyc = 0;
    int prev_cyc = 0;
    bit have_prev = 0;

    always @(negedge clk_75) begin
        if (started) begin
            n_cmp++;
            if (click_e !== exp_e || click_x !== exp_x || click_y !== exp_y) begin
                n_bad++;
                $display("FAIL model cyc=%0d: got e=%b x=%0d y=%0d, need e=%b x=%0d y=%0d",
                         cyc, click_e, click_x, click_y, exp_e, exp_x, exp_y);
            end
            if (rst) begin
                have_prev = 0;
            end else if (click_e === 1'b1) begin
                n_clicks++;
                last_cyc = cyc;
                if (have_prev) begin
                    n_cmp++;
                    if (cyc - prev_cyc < 2 * D + 2) begin
                        n_bad++;
                        $display("FAIL click_gap: got %0d cycles, need >= %0d", cyc - prev_cyc, 2 * D + 2);
                    end
                end
                have_prev = 1;
                prev_cyc  = cyc;
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(string name, int act, int lo, int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, need %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk_75);
    endtask

    int c0;
    int t0;

    initial begin
        tick(3);
        chk("reset_click_e", int'(click_e), 0);
        chk("reset_click_x", int'(click_x), 0);
        chk("reset_click_y", int'(click_y), 0);
        rst = 1'b0;
        tick(3);

        // Clean press at (300,200), held 20 cycles.
        c0 = n_clicks;
        mouse_xpos = 12'd300; mouse_ypos = 12'd200; mouse_left = 1'b1; t0 = cyc;
        tick(20);
        chk("clean_count", n_clicks - c0, 1);
        chk_rng("clean_latency", last_cyc - t0, 6, 8);
        chk("clean_x", int'(click_x), 300);
        chk("clean_y", int'(click_y), 200);
        mouse_left = 1'b0;
        tick(10);

        // 2-cycle glitch, then stable press at x=10.
        c0 = n_clicks;
        mouse_xpos = 12'd50; mouse_left = 1'b1;
        tick(2);
        mouse_left = 1'b0;
        tick(6);
        chk("glitch_no_click", n_clicks - c0, 0);
        mouse_xpos = 12'd10; mouse_left = 1'b1;
        tick(12);
        chk("bounce_count", n_clicks - c0, 1);
        chk("bounce_x", int'(click_x), 10);
        mouse_left = 1'b0;
        tick(10);

        // Clamp.
        mouse_xpos = 12'd1500; mouse_ypos = 12'd800; mouse_left = 1'b1;
        tick(12);
        chk("clamp_x", int'(click_x), 1023);
        chk("clamp_y", int'(click_y), 767);
        mouse_left = 1'b0;
        tick(10);

        // Cursor motion during debounce.
        mouse_xpos = 12'd100; mouse_ypos = 12'd5; mouse_left = 1'b1;
        tick(3);
        mouse_xpos = 12'd900;
        tick(10);
        chk("motion_x", int'(click_x), 100);
        mouse_left = 1'b0;
        tick(10);

        // Release bounce while held, then full release and new press.
        c0 = n_clicks;
        mouse_xpos = 12'd77; mouse_ypos = 12'd66; mouse_left = 1'b1;
        tick(12);
        mouse_left = 1'b0;
        tick(2);
        mouse_left = 1'b1;
        tick(10);
        chk("release_bounce_count", n_clicks - c0, 1);
        mouse_left = 1'b0;
        tick(10);
        mouse_left = 1'b1;
        tick(12);
        chk("second_click_count", n_clicks - c0, 2);
        mouse_left = 1'b0;
        tick(10);

        // Reset during press debounce with the button kept down.
        c0 = n_clicks;
        mouse_xpos = 12'd400; mouse_ypos = 12'd300; mouse_left = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(2);
        chk("rst_click_e", int'(click_e), 0);
        chk("rst_click_x", int'(click_x), 0);
        chk("rst_click_y", int'(click_y), 0);
        chk("rst_no_click", n_clicks - c0, 0);
        rst = 1'b0; t0 = cyc;
        tick(12);
        chk("after_rst_count", n_clicks - c0, 1);
        chk_rng("after_rst_latency", last_cyc - t0, 6, 8);
        chk("after_rst_x", int'(click_x), 400);
        mouse_left = 1'b0;
        tick(10);

        // Randomized level runs, cursor motion and occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            int len;
            mouse_left = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    mouse_xpos = 12'($urandom_range(0, 4095));
                    mouse_ypos = 12'($urandom_range(0, 4095));
                end
                tick(1);
            end
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 2));
                rst = 1'b0;
            end
        end
        mouse_left = 1'b0;
        tick(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
